dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
// - Shares the CPU's single data-memory port (8-bit addr, 16-bit data) between the CPU load/store stage and a host/debug port.
// - Sits between the CPU d_* interface and the data RAM; the host preloads and inspects memory while the CPU runs.
// - The CPU normally has priority; the host is granted idle slots, and the CPU is stalled when it loses a slot.
// PARAMETERS
// - AW          8   address width
// - DW          16  data width
// - STARVE_MAX  4   consecutive host losses before a forced host grant (used only with DMEM_ARB_FAIR_EN)
// PORTS
// - clock        in   1   system clock, rising edge
// - reset        in   1   asynchronous, active-high; clears all state
// - cpu_re       in   1   CPU load request this cycle
// - cpu_we       in   1   CPU store request this cycle
// - cpu_addr     in   AW  CPU address (d_addr)
// - cpu_wdata    in   DW  CPU store data (d_dataout)
// - cpu_rdata    out  DW  load data to CPU (d_datain), valid in the cycle after the granted load
// - cpu_stall    out  1   CPU access not serviced this cycle; CPU holds its request
// - host_req     in   1   host access request, held until host_gnt
// - host_we      in   1   1 = write, 0 = read; qualified by host_req
// - host_addr    in   AW  host address
// - host_wdata   in   DW  host write data
// - host_gnt     out  1   one-cycle pulse; host access performed at RAM this cycle
// - host_rvalid  out  1   one-cycle pulse in the cycle after a granted host read
// - host_rdata   out  DW  host read data, valid with host_rvalid
// - mem_addr     out  AW  RAM address
// - mem_wdata    out  DW  RAM write data
// - mem_we       out  1   RAM write enable
// - mem_rdata    in   DW  RAM read data, synchronous, 1-cycle latency
// BEHAVIOUR
// - Per-cycle owner select (combinational): cpu_act = cpu_re|cpu_we. Owner is CPU if cpu_act and no forced host slot; HOST if host_req and the CPU is not owner; otherwise NONE.
// - RAM mux: owner CPU -> cpu_addr/cpu_wdata/cpu_we; HOST -> host_*; NONE -> addr 0, mem_we = 0.
// - host_gnt = (owner == HOST). cpu_stall = cpu_act & (owner != CPU).
// - Read tagging: the registered rd_tag {NONE,CPU,HOST} records the owner of a granted read. Next cycle, rd_tag steers mem_rdata:
//   - CPU tag -> cpu_rdata updates
//   - HOST tag -> host_rdata updates and host_rvalid pulses
//   - otherwise both hold their last value
// - Back-to-back host reads are allowed at one per cycle; a CPU access in the rvalid cycle is legal (the RAM is pipelined).
// - Write is complete in the grant cycle; a read in the next cycle to the same address returns the new data.
// - Same-cycle CPU and host write to the same address: CPU wins; the host write lands later and overwrites.
// - Reset values: cpu_rdata = 0, host_rdata = 0, host_rvalid = 0, rd_tag = NONE, starve_cnt = 0. Combinational outputs follow their inputs.
// - Reset mid-read: the pending rvalid is dropped and never issued.
// - The block adds no latency: a CPU load grant returns data exactly like a direct RAM connection.
// CONFIGURATION
// - DMEM_ARB_FAIR_EN defined:
//   - starve_cnt increments each cycle host_req loses to the CPU, and clears on host_gnt.
//   - When starve_cnt == STARVE_MAX, the next contending cycle is a forced host slot: the host is granted and the CPU is stalled.
//   - The counter saturates and never wraps.
// - DMEM_ARB_FAIR_EN undefined: strict CPU priority; the host can starve indefinitely; starve_cnt is absent.
// STRUCTURE
// - Shared include cpu_defs.vh: owner/tag encodings OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_HOST=2'd2; AW/DW defaults shared with CPU.
// - One sub-module: arb_starve_counter (saturating counter, clear/inc, terminal flag), instantiated only under DMEM_ARB_FAIR_EN.
// TESTING
// - Reset asserted mid host read at addr 8'h10 -> host_rvalid never pulses; all registered outputs are 0.
// - Host write 8'h20=16'hFF00 with the CPU idle -> host_gnt same cycle, mem_we=1; host read 8'h20 -> host_rvalid next cycle with host_rdata 16'hFF00.
// - CPU load 8'h20 and host read 8'h30 in the same cycle -> CPU granted, cpu_stall=0; host granted next idle cycle; each rdata is routed to its own port.
// - Contention on stores: CPU writes 16'h00FF and host writes 16'h1234, both to 8'h05 -> final RAM value 16'h1234; cpu_stall never asserts.
// - FAIR_EN, STARVE_MAX=4: CPU active every cycle, host_req held -> host_gnt on the 5th contending cycle, cpu_stall=1 that cycle only.
// - FAIR_EN undefined, same stimulus for 50 cycles -> host_gnt stays 0.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared owner/read-tag encodings and default widths for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int AW_DEF         = 8;
  localparam int DW_DEF         = 16;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  // A slot produces read data next cycle only when its owner issued a read.
  function automatic owner_e rd_tag_next(input owner_e own, input logic cpu_re,
                                         input logic cpu_we, input logic host_we);
    owner_e tag;
    tag = OWN_NONE;
    if ((own == OWN_CPU) && cpu_re && !cpu_we) tag = OWN_CPU;
    else if ((own == OWN_HOST) && !host_we) tag = OWN_HOST;
    return tag;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_counter.sv
// arb_starve_counter: saturating count of consecutive host losses with a terminal flag.
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_term
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_C)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_term = (r_cnt == MAX_C);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous data-RAM port between the CPU load/store stage and a host port.
// Optional fairness (forced host slot after STARVE_MAX losses) is enabled by DMEM_ARB_FAIR_EN.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_re,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  logic          w_cpu_act;
  logic          w_force_host;
  owner_e        w_owner;
  owner_e        w_tag_nxt;
  owner_e        r_rd_tag;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_host_rdata;

  assign w_cpu_act = cpu_re | cpu_we;

`ifdef DMEM_ARB_FAIR_EN
  logic w_term;

  arb_starve_counter #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_owner == OWN_HOST),
    .i_inc  (host_req && (w_owner == OWN_CPU)),
    .o_term (w_term)
  );

  assign w_force_host = w_term & host_req & w_cpu_act;
`else
  assign w_force_host = 1'b0;
`endif

  always_comb begin
    w_owner = OWN_NONE;
    if (w_cpu_act && !w_force_host) w_owner = OWN_CPU;
    else if (host_req)              w_owner = OWN_HOST;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (w_owner)
      OWN_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
      end
      OWN_HOST: begin
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        mem_we    = host_we;
      end
      default: ;
    endcase
  end

  assign host_gnt  = (w_owner == OWN_HOST);
  assign cpu_stall = w_cpu_act & (w_owner != OWN_CPU);
  assign w_tag_nxt = rd_tag_next(w_owner, cpu_re, cpu_we, host_we);

  // Tag stage: steer the RAM's 1-cycle-late read data to whoever issued the read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_tag     <= OWN_NONE;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      r_rd_tag <= w_tag_nxt;
      if (r_rd_tag == OWN_CPU)  r_cpu_rdata  <= mem_rdata;
      if (r_rd_tag == OWN_HOST) r_host_rdata <= mem_rdata;
    end
  end

  // Data passes straight through in the tagged cycle so the CPU sees no extra latency.
  assign cpu_rdata   = (r_rd_tag == OWN_CPU)  ? mem_rdata : r_cpu_rdata;
  assign host_rdata  = (r_rd_tag == OWN_HOST) ? mem_rdata : r_host_rdata;
  assign host_rvalid = (r_rd_tag == OWN_HOST);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural synchronous RAM.
module tb_dmem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_re, cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        host_req, host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_gnt, host_rvalid;
  logic [15:0] host_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  logic [15:0] ram [0:255];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dmem_port_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_re      (cpu_re),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
  );

  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
  endtask

  task automatic host(input logic we, input logic [7:0] a, input logic [15:0] d);
    host_req = 1; host_we = we; host_addr = a; host_wdata = d;
  endtask

  initial begin
    int gnt_cnt;
    int stall_cnt;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    mem_rdata = 16'h0000;
    idle();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // preload 0x10 then read it back normally
    cyc(); host(1, 8'h10, 16'hBEEF); #1;
    chk("pre_gnt", host_gnt, 1);
    cyc(); host(0, 8'h10, 0); #1;
    chk("pre_rd_gnt", host_gnt, 1);
    cyc(); idle(); #1;
    chk("pre_rvalid", host_rvalid, 1);
    chk("pre_rdata", host_rdata, 16'hBEEF);

    // reset asserted while a host read is pending
    cyc(); host(0, 8'h10, 0); #1;
    chk("rstrd_gnt", host_gnt, 1);
    cyc(); idle(); reset = 1'b1; #1;
    chk("rstrd_rvalid", host_rvalid, 0);
    chk("rstrd_host_rdata", host_rdata, 0);
    chk("rstrd_cpu_rdata", cpu_rdata, 0);
    cyc(); reset = 1'b0; #1;
    chk("rstrd_rvalid_after", host_rvalid, 0);
    chk("rstrd_host_rdata_after", host_rdata, 0);

    // host write then read with CPU idle
    cyc(); host(1, 8'h20, 16'hFF00); #1;
    chk("hw_gnt", host_gnt, 1);
    chk("hw_mem_we", mem_we, 1);
    chk("hw_mem_addr", mem_addr, 8'h20);
    chk("hw_mem_wdata", mem_wdata, 16'hFF00);
    cyc(); host(0, 8'h20, 0); #1;
    chk("hr_gnt", host_gnt, 1);
    chk("hr_mem_we", mem_we, 0);
    chk("hr_rvalid_early", host_rvalid, 0);
    cyc(); idle(); #1;
    chk("hr_rvalid", host_rvalid, 1);
    chk("hr_rdata", host_rdata, 16'hFF00);
    cyc(); #1;
    chk("hr_rvalid_pulse", host_rvalid, 0);
    chk("hr_rdata_hold", host_rdata, 16'hFF00);

    // CPU load and host read in the same cycle
    cyc(); host(1, 8'h30, 16'h0A5A); #1;
    cyc(); cpu_re = 1; cpu_addr = 8'h20; host(0, 8'h30, 0); #1;
    chk("mix_cpu_stall", cpu_stall, 0);
    chk("mix_host_gnt_a", host_gnt, 0);
    chk("mix_mem_addr_a", mem_addr, 8'h20);
    cyc(); cpu_re = 0; #1;
    chk("mix_host_gnt_b", host_gnt, 1);
    chk("mix_mem_addr_b", mem_addr, 8'h30);
    chk("mix_cpu_rdata", cpu_rdata, 16'hFF00);
    chk("mix_rvalid_b", host_rvalid, 0);
    cyc(); idle(); #1;
    chk("mix_rvalid_c", host_rvalid, 1);
    chk("mix_host_rdata", host_rdata, 16'h0A5A);
    chk("mix_cpu_rdata_hold", cpu_rdata, 16'hFF00);

    // same-cycle stores to one address
    cyc(); cpu_we = 1; cpu_addr = 8'h05; cpu_wdata = 16'h00FF; host(1, 8'h05, 16'h1234); #1;
    chk("st_cpu_stall_a", cpu_stall, 0);
    chk("st_host_gnt_a", host_gnt, 0);
    chk("st_mem_wdata_a", mem_wdata, 16'h00FF);
    cyc(); cpu_we = 0; #1;
    chk("st_cpu_stall_b", cpu_stall, 0);
    chk("st_host_gnt_b", host_gnt, 1);
    chk("st_mem_wdata_b", mem_wdata, 16'h1234);
    cyc(); host(0, 8'h05, 0); #1;
    cyc(); idle(); #1;
    chk("st_final", host_rdata, 16'h1234);

    // CPU busy every cycle while the host waits
    cyc(); cpu_re = 1; cpu_addr = 8'h00; host(0, 8'h20, 0);
`ifdef DMEM_ARB_FAIR_EN
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("fair_gnt_%0d", i), host_gnt, (i == 4) ? 1 : 0);
      chk($sformatf("fair_stall_%0d", i), cpu_stall, (i == 4) ? 1 : 0);
      if (i == 4) host_req = 0;
      cyc();
    end
    #1;
    chk("fair_rvalid", host_rvalid, 1);
    chk("fair_rdata", host_rdata, 16'hFF00);
`else
    gnt_cnt = 0;
    stall_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (host_gnt) gnt_cnt++;
      if (cpu_stall) stall_cnt++;
      cyc();
    end
    chk("strict_gnt_cnt", gnt_cnt, 0);
    chk("strict_stall_cnt", stall_cnt, 0);
    #1;
    chk("strict_rvalid", host_rvalid, 0);
`endif
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
